// File: rtl/rmt_ctrl_arbiter_if.sv
// rmt_ctrl_arbiter_if: AXI-Stream bundle carrying N parallel lanes.
//   tdata  N*DATA_W    lane i occupies slice i
//   tkeep  N*DATA_W/8  per-lane byte keep
//   tuser  N*USER_W    per-lane user sideband
//   tvalid N           per-lane valid
//   tready N           per-lane ready (driven by the slave)
//   tlast  N           per-lane end of packet
// master drives the payload and reads tready; slave does the opposite.
interface rmt_ctrl_arbiter_if #(
   parameter int DATA_W = 512,
   parameter int USER_W = 128,
   parameter int N      = 1
);
   logic [N*DATA_W-1:0]   tdata;
   logic [N*DATA_W/8-1:0] tkeep;
   logic [N*USER_W-1:0]   tuser;
   logic [N-1:0]          tvalid;
   logic [N-1:0]          tready;
   logic [N-1:0]          tlast;
   modport master (output tdata, tkeep, tuser, tvalid, tlast, input tready);
   modport slave  (input tdata, tkeep, tuser, tvalid, tlast, output tready);
endinterface

// File: rtl/rmt_ctrl_arbiter.sv
// rmt_ctrl_arbiter: packet-atomic round-robin merge of NUM_REQ AXI-Stream control sources.
//   clk          single clock
//   areset       asynchronous, active-high reset
//   s_axis       NUM_REQ-lane source bundle (slave side)
//   m_axis       single-lane merged output bundle (master side), registered
//   grant_valid  high while a packet grant is held
//   grant_idx    current (or most recent) grantee
//   wdog_err     one-cycle pulse when a packet is truncated at MAX_BEATS
// Define RMT_CTRL_ARB_WDOG_EN to enable the packet-length watchdog.
module rmt_ctrl_arbiter #(
   parameter int C_S_AXIS_DATA_WIDTH  = 512,
   parameter int C_S_AXIS_TUSER_WIDTH = 128,
   parameter int NUM_REQ              = 2,
   parameter int GNT_W                = 2,
   parameter int MAX_BEATS            = 16
) (
   input  logic               clk,
   input  logic               areset,
   rmt_ctrl_arbiter_if.slave  s_axis,
   rmt_ctrl_arbiter_if.master m_axis,
   output logic               grant_valid,
   output logic [GNT_W-1:0]   grant_idx,
   output logic               wdog_err
);
   localparam int DW = C_S_AXIS_DATA_WIDTH;
   localparam int KW = C_S_AXIS_DATA_WIDTH / 8;
   localparam int UW = C_S_AXIS_TUSER_WIDTH;

   if (NUM_REQ < 2 || NUM_REQ > 4 || (1 << GNT_W) < NUM_REQ || MAX_BEATS < 1) begin : g_bad_cfg
      $error("rmt_ctrl_arbiter: illegal NUM_REQ/GNT_W/MAX_BEATS");
   end

   typedef enum logic {IDLE, BUSY} state_t;
   state_t state, state_nxt;

   logic [GNT_W-1:0] last_grant, pick;
   logic             any_req, sel_valid, sel_last, out_rdy, acc, trunc, drop;
   logic [DW-1:0]    sel_data;
   logic [KW-1:0]    sel_keep;
   logic [UW-1:0]    sel_user;

   always_ff @(posedge clk or posedge areset) begin
      if (areset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      any_req   = 1'b0;
      pick      = last_grant;
      sel_valid = 1'b0;
      sel_last  = 1'b0;
      sel_data  = '0;
      sel_keep  = '0;
      sel_user  = '0;
      // rotating priority: the first requester after last_grant wins
      for (int k = 1; k <= NUM_REQ; k++)
         for (int i = 0; i < NUM_REQ; i++)
            if (!any_req && s_axis.tvalid[i] && i == (int'(last_grant) + k) % NUM_REQ) begin
               any_req = 1'b1;
               pick    = GNT_W'(i);
            end
      for (int i = 0; i < NUM_REQ; i++)
         if (GNT_W'(i) == grant_idx) begin
            sel_valid = s_axis.tvalid[i];
            sel_last  = s_axis.tlast[i];
            sel_data  = s_axis.tdata[i*DW +: DW];
            sel_keep  = s_axis.tkeep[i*KW +: KW];
            sel_user  = s_axis.tuser[i*UW +: UW];
         end
      // while dropping, beats are swallowed regardless of the output slot
      out_rdy = drop || !m_axis.tvalid[0] || m_axis.tready[0];
      s_axis.tready = '0;
      for (int i = 0; i < NUM_REQ; i++)
         s_axis.tready[i] = state == BUSY && GNT_W'(i) == grant_idx && out_rdy;
      acc       = state == BUSY && sel_valid && out_rdy;
      state_nxt = state == IDLE ? (any_req ? BUSY : IDLE) : (acc && sel_last ? IDLE : BUSY);
   end

   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         grant_idx     <= '0;
         last_grant    <= GNT_W'(NUM_REQ - 1);
         m_axis.tvalid <= '0;
         m_axis.tlast  <= '0;
         m_axis.tdata  <= '0;
         m_axis.tkeep  <= '0;
         m_axis.tuser  <= '0;
      end else begin
         if (state == IDLE && any_req) grant_idx <= pick;
         if (acc && sel_last) last_grant <= grant_idx;
         if (acc && !drop) begin
            m_axis.tvalid <= 1'b1;
            m_axis.tlast  <= sel_last || trunc;
            m_axis.tdata  <= sel_data;
            m_axis.tkeep  <= sel_keep;
            m_axis.tuser  <= sel_user;
         end else if (m_axis.tready[0]) begin
            m_axis.tvalid <= 1'b0;
         end
      end
   end

   assign grant_valid = state == BUSY;

`ifdef RMT_CTRL_ARB_WDOG_EN
   localparam int CW = $clog2(MAX_BEATS + 1);
   logic [CW-1:0] beat_cnt;

   // beat_cnt holds the beats already forwarded, so this is beat MAX_BEATS
   assign trunc = acc && !drop && !sel_last && beat_cnt == CW'(MAX_BEATS - 1);

   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         beat_cnt <= '0;
         drop     <= 1'b0;
         wdog_err <= 1'b0;
      end else begin
         wdog_err <= trunc;
         if (state == IDLE) beat_cnt <= '0;
         else if (acc && !drop) beat_cnt <= beat_cnt + CW'(1);
         if (acc && sel_last) drop <= 1'b0;
         else if (trunc) drop <= 1'b1;
      end
   end
`else
   assign trunc    = 1'b0;
   assign drop     = 1'b0;
   assign wdog_err = 1'b0;
`endif
endmodule

// File: tb/tb_rmt_ctrl_arbiter.sv
// tb_rmt_ctrl_arbiter: directed bench for a 2-source and a 3-source (MAX_BEATS=4) arbiter.
module tb_rmt_ctrl_arbiter;
   logic       clk, areset;
   logic       ga_v, wa, gb_v, wb;
   logic [1:0] ga_idx, gb_idx;
   int         total = 0, passed = 0, fails = 0;

   rmt_ctrl_arbiter_if #(.DATA_W(32), .USER_W(8), .N(2)) sa ();
   rmt_ctrl_arbiter_if #(.DATA_W(32), .USER_W(8), .N(1)) ma ();
   rmt_ctrl_arbiter_if #(.DATA_W(32), .USER_W(8), .N(3)) sb ();
   rmt_ctrl_arbiter_if #(.DATA_W(32), .USER_W(8), .N(1)) mb ();

   rmt_ctrl_arbiter #(.C_S_AXIS_DATA_WIDTH(32), .C_S_AXIS_TUSER_WIDTH(8), .NUM_REQ(2), .GNT_W(2)) dut_a (
      .clk(clk), .areset(areset), .s_axis(sa), .m_axis(ma),
      .grant_valid(ga_v), .grant_idx(ga_idx), .wdog_err(wa));

   rmt_ctrl_arbiter #(.C_S_AXIS_DATA_WIDTH(32), .C_S_AXIS_TUSER_WIDTH(8), .NUM_REQ(3), .GNT_W(2), .MAX_BEATS(4)) dut_b (
      .clk(clk), .areset(areset), .s_axis(sb), .m_axis(mb),
      .grant_valid(gb_v), .grant_idx(gb_idx), .wdog_err(wb));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL timeout: bench did not reach its end");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic put_a(input int i, input logic [31:0] d, input logic l);
      sa.tdata[i*32 +: 32] = d;
      sa.tkeep[i*4 +: 4]   = 4'hF;
      sa.tuser[i*8 +: 8]   = d[7:0] ^ 8'h5A;
      sa.tlast[i]          = l;
   endtask

   task automatic put_b(input int i, input logic [31:0] d, input logic l);
      sb.tdata[i*32 +: 32] = d;
      sb.tkeep[i*4 +: 4]   = 4'hF;
      sb.tuser[i*8 +: 8]   = d[7:0] ^ 8'h5A;
      sb.tlast[i]          = l;
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   initial begin
      areset = 1'b1;
      sa.tvalid = '0; sa.tlast = '0; sa.tdata = '0; sa.tkeep = '0; sa.tuser = '0;
      sb.tvalid = '0; sb.tlast = '0; sb.tdata = '0; sb.tkeep = '0; sb.tuser = '0;
      ma.tready = 1'b1;
      mb.tready = 1'b1;
      step();
      chk("rst_tvalid", ma.tvalid, 0);
      chk("rst_tdata", ma.tdata, 0);
      chk("rst_gv", ga_v, 0);
      chk("rst_gidx", ga_idx, 0);
      chk("rst_wdog", wa, 0);
      chk("rst_sready", sa.tready, 0);
      areset = 1'b0;
      // single 3-beat packet from src0
      put_a(0, 32'h11, 1'b0);
      sa.tvalid = 2'b01;
      #1 chk("t1_idle_ready", sa.tready, 2'b00);
      step();
      chk("t1_gv", ga_v, 1);
      chk("t1_gidx", ga_idx, 0);
      chk("t1_ready", sa.tready, 2'b01);
      chk("t1_bubble", ma.tvalid, 0);
      step();
      chk("t1_b0_valid", ma.tvalid, 1);
      chk("t1_b0_data", ma.tdata, 32'h11);
      chk("t1_b0_last", ma.tlast, 0);
      chk("t1_b0_user", ma.tuser, 8'h4B);
      chk("t1_b0_keep", ma.tkeep, 4'hF);
      put_a(0, 32'h12, 1'b0);
      step();
      chk("t1_b1_data", ma.tdata, 32'h12);
      chk("t1_b1_last", ma.tlast, 0);
      put_a(0, 32'h13, 1'b1);
      step();
      chk("t1_b2_data", ma.tdata, 32'h13);
      chk("t1_b2_last", ma.tlast, 1);
      chk("t1_idle_gv", ga_v, 0);
      chk("t1_hold_gidx", ga_idx, 0);
      sa.tvalid = 2'b00;
      step();
      chk("t1_drain", ma.tvalid, 0);
      // both sources contend with 2-beat packets: order 0,1,0,1
      areset = 1'b1;
      #1 areset = 1'b0;
      put_a(0, 32'hA0, 1'b0);
      put_a(1, 32'hB0, 1'b0);
      sa.tvalid = 2'b11;
      step();
      chk("t2_g0_idx", ga_idx, 0);
      chk("t2_g0_ready", sa.tready, 2'b01);
      step();
      chk("t2_a0", ma.tdata, 32'hA0);
      put_a(0, 32'hA1, 1'b1);
      step();
      chk("t2_a1", ma.tdata, 32'hA1);
      chk("t2_a1_last", ma.tlast, 1);
      chk("t2_a1_gv", ga_v, 0);
      put_a(0, 32'hA2, 1'b0);
      #1 chk("t2_idle_ready", sa.tready, 2'b00);
      step();
      chk("t2_g1_idx", ga_idx, 1);
      chk("t2_g1_ready", sa.tready, 2'b10);
      chk("t2_gap", ma.tvalid, 0);
      step();
      chk("t2_b0", ma.tdata, 32'hB0);
      put_a(1, 32'hB1, 1'b1);
      step();
      chk("t2_b1", ma.tdata, 32'hB1);
      chk("t2_b1_last", ma.tlast, 1);
      put_a(1, 32'hB2, 1'b0);
      step();
      chk("t2_g2_idx", ga_idx, 0);
      step();
      chk("t2_a2", ma.tdata, 32'hA2);
      put_a(0, 32'hA3, 1'b1);
      step();
      chk("t2_a3", ma.tdata, 32'hA3);
      chk("t2_a3_last", ma.tlast, 1);
      sa.tvalid = 2'b10;
      step();
      chk("t2_g3_idx", ga_idx, 1);
      chk("t2_g3_ready", sa.tready, 2'b10);
      // src1 second beat stalled by downstream for 4 cycles
      step();
      chk("t3_b2", ma.tdata, 32'hB2);
      put_a(1, 32'hB3, 1'b1);
      ma.tready = 1'b0;
      #1 chk("t3_stall_ready", sa.tready, 2'b00);
      for (int n = 0; n < 3; n++) begin
         step();
         chk("t3_stall_data", ma.tdata, 32'hB2);
         chk("t3_stall_valid", ma.tvalid, 1);
         chk("t3_stall_sready", sa.tready, 2'b00);
      end
      step();
      chk("t3_hold_data", ma.tdata, 32'hB2);
      ma.tready = 1'b1;
      #1 chk("t3_resume_ready", sa.tready, 2'b10);
      step();
      chk("t3_b3", ma.tdata, 32'hB3);
      chk("t3_b3_last", ma.tlast, 1);
      chk("t3_b3_valid", ma.tvalid, 1);
      chk("t3_idle", ga_v, 0);
      sa.tvalid = 2'b00;
      step();
      chk("t3_drain", ma.tvalid, 0);
      // reset in the middle of a 5-beat src0 packet
      put_a(0, 32'hC0, 1'b0);
      sa.tvalid = 2'b01;
      step();
      step();
      chk("t4_c0", ma.tdata, 32'hC0);
      put_a(0, 32'hC1, 1'b0);
      step();
      chk("t4_c1", ma.tdata, 32'hC1);
      put_a(0, 32'hC2, 1'b0);
      areset = 1'b1;
      sa.tvalid = 2'b00;
      #1;
      chk("t4_rst_valid", ma.tvalid, 0);
      chk("t4_rst_data", ma.tdata, 0);
      chk("t4_rst_last", ma.tlast, 0);
      chk("t4_rst_gv", ga_v, 0);
      areset = 1'b0;
      put_a(0, 32'hD0, 1'b0);
      put_a(1, 32'hE0, 1'b0);
      sa.tvalid = 2'b11;
      step();
      chk("t4_regrant_idx", ga_idx, 0);
      chk("t4_regrant_gv", ga_v, 1);
      sa.tvalid = 2'b00;
      step();
      step();
      chk("t4_hold_gv", ga_v, 1);
      chk("t4_hold_idx", ga_idx, 0);
      chk("t4_hold_valid", ma.tvalid, 0);
      // 3-source arbiter, src2 alone with single-beat packets
      put_b(2, 32'hD0, 1'b1);
      sb.tvalid = 3'b100;
      step();
      chk("t6_gidx", gb_idx, 2);
      chk("t6_ready", sb.tready, 3'b100);
      step();
      chk("t6_d0", mb.tdata, 32'hD0);
      chk("t6_d0_last", mb.tlast, 1);
      chk("t6_d0_gv", gb_v, 0);
      put_b(2, 32'hD1, 1'b1);
      step();
      chk("t6_gap0", mb.tvalid, 0);
      chk("t6_regrant", gb_v, 1);
      step();
      chk("t6_d1", mb.tdata, 32'hD1);
      chk("t6_d1_valid", mb.tvalid, 1);
      put_b(2, 32'hD2, 1'b1);
      step();
      chk("t6_gap1", mb.tvalid, 0);
      step();
      chk("t6_d2", mb.tdata, 32'hD2);
      sb.tvalid = 3'b000;
      step();
      chk("t6_drain", mb.tvalid, 0);
      // 6-beat src0 packet against MAX_BEATS=4, src1 waiting
      put_b(0, 32'hE0, 1'b0);
      put_b(1, 32'hF0, 1'b1);
      sb.tvalid = 3'b011;
      step();
      chk("t5_gidx", gb_idx, 0);
      chk("t5_ready", sb.tready, 3'b001);
      step();
      chk("t5_e0", mb.tdata, 32'hE0);
      put_b(0, 32'hE1, 1'b0);
      step();
      chk("t5_e1", mb.tdata, 32'hE1);
      put_b(0, 32'hE2, 1'b0);
      step();
      chk("t5_e2", mb.tdata, 32'hE2);
      chk("t5_e2_wdog", wb, 0);
      put_b(0, 32'hE3, 1'b0);
      step();
      chk("t5_e3", mb.tdata, 32'hE3);
`ifdef RMT_CTRL_ARB_WDOG_EN
      chk("t5_e3_last", mb.tlast, 1);
      chk("t5_e3_wdog", wb, 1);
`else
      chk("t5_e3_last", mb.tlast, 0);
      chk("t5_e3_wdog", wb, 0);
`endif
      put_b(0, 32'hE4, 1'b0);
      #1 chk("t5_e4_ready", sb.tready, 3'b001);
      step();
      chk("t5_e4_wdog", wb, 0);
`ifdef RMT_CTRL_ARB_WDOG_EN
      chk("t5_e4_dropped", mb.tvalid, 0);
`else
      chk("t5_e4", mb.tdata, 32'hE4);
      chk("t5_e4_last", mb.tlast, 0);
`endif
      put_b(0, 32'hE5, 1'b1);
      step();
      chk("t5_e5_gv", gb_v, 0);
`ifdef RMT_CTRL_ARB_WDOG_EN
      chk("t5_e5_dropped", mb.tvalid, 0);
`else
      chk("t5_e5", mb.tdata, 32'hE5);
      chk("t5_e5_last", mb.tlast, 1);
`endif
      sb.tvalid = 3'b010;
      step();
      chk("t5_next_gidx", gb_idx, 1);
      step();
      chk("t5_f0", mb.tdata, 32'hF0);
      chk("t5_f0_last", mb.tlast, 1);
      sb.tvalid = 3'b000;
      step();
      $display("%0d/%0d checks passed", passed, total);
      if (fails != 0) $display("%0d comparisons did not match", fails);
      $finish;
   end
endmodule

// File: doc/rmt_ctrl_arbiter.md
Name: rmt_ctrl_arbiter

Overview:
- Packet-atomic round-robin arbiter that merges up to four AXI-Stream control-packet sources into the single control chain (parser → stage0..4 → deparser).
- Typical sources: in-band control packets from pkt_filter and a host/config injection port.
- Once a source is granted, a whole packet (through tlast) passes before any other source can win.
- Provides a registered output slice and grant observability.

Parameters:
- C_S_AXIS_DATA_WIDTH, 512, tdata width per source and on the output.
- C_S_AXIS_TUSER_WIDTH, 128, tuser width per source and on the output.
- NUM_REQ, 2, number of requesting sources; legal range 2..4.
- GNT_W, 2, width of grant_idx; must be ≥ clog2(NUM_REQ).
- MAX_BEATS, 16, watchdog packet-length limit in beats; used only with the optional feature.

Ports:
- clk  in  1  single clock for all logic.
- areset  in  1  asynchronous, active-high reset.
- s_axis_tdata  in  NUM_REQ*C_S_AXIS_DATA_WIDTH  source i occupies slice i.
- s_axis_tkeep  in  NUM_REQ*C_S_AXIS_DATA_WIDTH/8  per-source keep.
- s_axis_tuser  in  NUM_REQ*C_S_AXIS_TUSER_WIDTH  per-source user.
- s_axis_tvalid  in  NUM_REQ  per-source valid.
- s_axis_tready  out  NUM_REQ  per-source ready.
- s_axis_tlast  in  NUM_REQ  per-source last.
- m_axis_tdata  out  C_S_AXIS_DATA_WIDTH  merged data.
- m_axis_tkeep  out  C_S_AXIS_DATA_WIDTH/8  merged keep.
- m_axis_tuser  out  C_S_AXIS_TUSER_WIDTH  merged user.
- m_axis_tvalid  out  1  merged valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tlast  out  1  merged last.
- grant_valid  out  1  high while in BUSY.
- grant_idx  out  GNT_W  index of the current (or last) grantee.
- wdog_err  out  1  one-cycle pulse on a watchdog truncation.

Behaviour:
Clock and reset:
- One clock; reset is asynchronous and active-high.

Reset values:
- All outputs 0.
- State = IDLE; last_grant = NUM_REQ-1, so source 0 wins first.
- Beat counter = 0; drop flag = 0.
- Reset asserted mid-packet discards the partial packet and clears the output register without emitting tlast. Upstream sources are reset together with this block.

State machine IDLE / BUSY:
- IDLE:
  - s_axis_tready = 0 for all sources.
  - If any s_axis_tvalid is high, select the first valid index searching last_grant+1, +2, … modulo NUM_REQ.
  - Register that index into grant_idx and move to BUSY next cycle (one-cycle arbitration bubble).
  - Request inputs sampled in IDLE only; requests appearing during BUSY wait for the next IDLE.
- BUSY:
  - s_axis_tready[g] = (~m_axis_tvalid | m_axis_tready) for the grantee g only, or 1 while the drop flag is set.
  - All other sources' ready = 0.
  - An accepted beat loads the output register: tdata/tkeep/tuser/tlast, m_axis_tvalid = 1.
  - Output latency is 1 cycle after the input handshake.
  - Full throughput: 1 beat/cycle while m_axis_tready is held high.
  - Accepting a beat with tlast=1: last_grant ← g, return to IDLE.
  - grant_valid = (state == BUSY).

Output register:
- m_axis_tvalid clears on (m_axis_tready & ~new beat).
- Output is held stable while m_axis_tready = 0 (AXIS rule: no change while valid & ~ready).

Boundary conditions:
- Single-beat packet (tvalid & tlast on the first beat): one beat out, straight back to IDLE.
- Grantee drops tvalid mid-packet: stay in BUSY, grant is held indefinitely.
- Simultaneous requests: strict rotation, no starvation.
- A single active source alone: it is granted every IDLE.
- Back-to-back packets from the same source: a one-cycle gap between packets.

Optional Feature:
Macro RMT_CTRL_ARB_WDOG_EN.

Defined:
- A beat counter increments on each accepted beat in BUSY.
- If the accepted beat is number MAX_BEATS and its tlast = 0:
  - the beat is forwarded with m_axis_tlast forced to 1;
  - wdog_err pulses for 1 cycle;
  - the drop flag is set.
- While the drop flag is set:
  - the grantee's beats are accepted (ready = 1) and discarded;
  - nothing is written to the output register.
- The grantee's tlast clears the flag, updates last_grant and returns to IDLE.
- The counter resets on each IDLE entry.

Not defined:
- No counter and no drop flag; packets of any length pass unmodified.
- wdog_err tied to 0.

Test Plan:
1. Reset, then src0 sends a 3-beat packet (tdata 0x11,0x12,0x13), m_axis_tready = 1 → output beats 0x11..0x13 on 3 consecutive cycles, starting 1 cycle after the first input handshake; tlast only on 0x13; grant_idx = 0.
2. src0 and src1 both valid in IDLE, each sending 2-beat packets repeatedly → grant order 0,1,0,1; no interleaving of beats within a packet.
3. src1 mid-packet, m_axis_tready low for 4 cycles → s_axis_tready[1] = 0 and m_axis_tdata stable for the whole stall; no beat lost or duplicated.
4. areset pulsed while src0 is on beat 2 of 5 → m_axis_tvalid = 0 immediately; state IDLE; the next grant goes to src0.
5. With RMT_CTRL_ARB_WDOG_EN and MAX_BEATS = 4, src0 sends a 6-beat packet → 4 beats out with tlast on beat 4; one wdog_err pulse; beats 5–6 dropped; src1 granted afterward.
6. NUM_REQ = 3, only src2 active, sending single-beat packets → every packet is forwarded, with one idle cycle between beats.
